// File: rtl/axi_rd_slave_mem.sv
// AXI4 read-only slave over an internal word-addressed RAM, one AR at a time,
// with a registered R output stage and a side port for preloading RAM contents.
module axi_rd_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_DEPTH_LOG2   = 10
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic                          MEM_WE,
    input  logic [C_MEM_DEPTH_LOG2-1:0]   MEM_WADDR,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] MEM_WDATA
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int SHIFT = $clog2(C_S_AXI_DATA_WIDTH / 8);
    localparam int DEPTH = 1 << C_MEM_DEPTH_LOG2;

    typedef enum logic {IDLE, DATA} state_t;

    state_t                          state, state_nxt;
    logic [AW-1:0]                   idx, load_idx;
    logic [7:0]                      cnt, load_cnt, len, load_len;
    logic [1:0]                      burst, load_burst;
    logic [C_S_AXI_ID_WIDTH-1:0]     id, load_id;
    logic                            load, last_hs, load_err;
    logic [C_S_AXI_DATA_WIDTH-1:0]   load_data;
    logic [C_S_AXI_DATA_WIDTH-1:0]   mem [DEPTH];
    logic                            unused_arsize;

    assign unused_arsize = ^S_AXI_ARSIZE;

    always_ff @(posedge ACLK) begin
        if (MEM_WE)
            mem[MEM_WADDR] <= MEM_WDATA;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Decide whether a beat is loaded this edge and which word/count it carries.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        last_hs    = 1'b0;
        load_idx   = idx;
        load_cnt   = cnt;
        load_len   = len;
        load_burst = burst;
        load_id    = id;
        case (state)
            IDLE: begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    state_nxt  = DATA;
                    load       = 1'b1;
                    load_idx   = S_AXI_ARADDR >> SHIFT;
                    load_cnt   = 8'd0;
                    load_len   = S_AXI_ARLEN;
                    load_burst = S_AXI_ARBURST;
                    load_id    = S_AXI_ARID;
                end
            end
            DATA: begin
                if (S_AXI_RVALID && S_AXI_RREADY) begin
                    if (cnt == len) begin
                        state_nxt = IDLE;
                        last_hs   = 1'b1;
                    end else begin
                        load     = 1'b1;
                        load_cnt = cnt + 8'd1;
                        load_idx = (burst == 2'b00) ? idx : idx + AW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // WRAP/reserved bursts and words beyond the RAM both answer SLVERR with zero data.
    always_comb begin
        load_err  = load_burst[1] | (|(load_idx >> C_MEM_DEPTH_LOG2));
        load_data = load_err ? '0 : mem[load_idx[C_MEM_DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            idx           <= '0;
            cnt           <= '0;
            len           <= '0;
            burst         <= '0;
            id            <= '0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RID     <= '0;
        end else begin
            S_AXI_ARREADY <= (state_nxt == IDLE);
            if (load) begin
                idx          <= load_idx;
                cnt          <= load_cnt;
                len          <= load_len;
                burst        <= load_burst;
                id           <= load_id;
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= load_data;
                S_AXI_RRESP  <= load_err ? 2'b10 : 2'b00;
                S_AXI_RLAST  <= (load_cnt == load_len);
                S_AXI_RID    <= load_id;
            end else if (last_hs) begin
                S_AXI_RVALID <= 1'b0;
                S_AXI_RLAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// Directed self-checking bench for axi_rd_slave_mem: INCR/FIXED/WRAP bursts,
// stalls, out-of-range beats, back-to-back requests and mid-burst reset.
module tb_axi_rd_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [0:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    axi_rd_slave_mem #(
        .C_S_AXI_ID_WIDTH  (1),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .C_MEM_DEPTH_LOG2  (10)
    ) dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .S_AXI_ARID   (arid),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARLEN  (arlen),
        .S_AXI_ARSIZE (arsize),
        .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RID    (rid),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RLAST  (rlast),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .MEM_WE       (mem_we),
        .MEM_WADDR    (mem_waddr),
        .MEM_WDATA    (mem_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue_ar(input logic [0:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        chk("ar_ready_before", 32'(arready), 32'd1);
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arburst = burst;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("ar_ready_after_hs", 32'(arready), 32'd0);
    endtask

    task automatic beat(input string tag, input logic [31:0] data, input logic [1:0] resp,
                        input logic last, input logic [0:0] id);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rdata"},  rdata, data);
        chk({tag, "_rresp"},  32'(rresp), 32'(resp));
        chk({tag, "_rlast"},  32'(rlast), 32'(last));
        chk({tag, "_rid"},    32'(rid), 32'(id));
    endtask

    task automatic burst_done(input string tag);
        chk({tag, "_end_rvalid"},  32'(rvalid), 32'd0);
        chk({tag, "_end_rlast"},   32'(rlast), 32'd0);
        chk({tag, "_end_arready"}, 32'(arready), 32'd1);
    endtask

    initial begin
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int b;

        rst = 1'b1; arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b0; rready = 1'b1; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        tick();
        tick();
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid",  32'(rvalid), 32'd0);
        chk("rst_rlast",   32'(rlast), 32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        chk("rst_rresp",   32'(rresp), 32'd0);
        chk("rst_rid",     32'(rid), 32'd0);

        rst = 1'b0;
        chk("post_rst_arready_low", 32'(arready), 32'd0);
        tick();
        chk("post_rst_arready_high", 32'(arready), 32'd1);

        // Preload words 0..15 plus the top two RAM words.
        for (int i = 0; i < 16; i++) begin
            mem_we = 1'b1; mem_waddr = 10'(i); mem_wdata = 32'hA000_0000 + 32'(i);
            tick();
        end
        mem_we = 1'b1; mem_waddr = 10'd1022; mem_wdata = 32'hC000_03FE; tick();
        mem_we = 1'b1; mem_waddr = 10'd1023; mem_wdata = 32'hC000_03FF; tick();
        mem_we = 1'b0;

        // INCR 0x10, 4 beats, no stalls
        issue_ar(1'b1, 32'h10, 8'd3, 2'b01);
        for (int k = 0; k < 4; k++) begin
            beat($sformatf("incr_b%0d", k), 32'hA000_0004 + 32'(k), 2'b00, k == 3, 1'b1);
            tick();
        end
        burst_done("incr");

        // Same burst with RREADY stalls
        issue_ar(1'b0, 32'h10, 8'd3, 2'b01);
        b = 0;
        for (int p = 0; p < 7; p++) begin
            rready = pat[p][0];
            beat($sformatf("stall_c%0d", p), 32'hA000_0004 + 32'(b), 2'b00, b == 3, 1'b0);
            tick();
            if (pat[p] != 0) b++;
        end
        rready = 1'b1;
        burst_done("stall");

        // FIXED 0x8, 3 beats of word 2
        issue_ar(1'b1, 32'h8, 8'd2, 2'b00);
        for (int k = 0; k < 3; k++) begin
            beat($sformatf("fixed_b%0d", k), 32'hA000_0002, 2'b00, k == 2, 1'b1);
            tick();
        end
        burst_done("fixed");

        // INCR running off the top of the RAM
        issue_ar(1'b0, 32'hFF8, 8'd3, 2'b01);
        beat("oor_b0", 32'hC000_03FE, 2'b00, 1'b0, 1'b0); tick();
        beat("oor_b1", 32'hC000_03FF, 2'b00, 1'b0, 1'b0); tick();
        beat("oor_b2", 32'h0, 2'b10, 1'b0, 1'b0); tick();
        beat("oor_b3", 32'h0, 2'b10, 1'b1, 1'b0); tick();
        burst_done("oor");

        // WRAP burst is refused beat by beat
        issue_ar(1'b1, 32'h0, 8'd1, 2'b10);
        beat("wrap_b0", 32'h0, 2'b10, 1'b0, 1'b1); tick();
        beat("wrap_b1", 32'h0, 2'b10, 1'b1, 1'b1); tick();
        burst_done("wrap");

        // Back-to-back single-beat requests with ARVALID held
        arid = 1'b1; araddr = 32'h14; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            beat($sformatf("b2b_%0d", i), 32'hA000_0005, 2'b00, 1'b1, 1'b1);
            chk($sformatf("b2b_%0d_arready_low", i), 32'(arready), 32'd0);
            if (i == 2) arvalid = 1'b0;
            tick();
            chk($sformatf("b2b_%0d_rvalid_low", i), 32'(rvalid), 32'd0);
            chk($sformatf("b2b_%0d_arready_high", i), 32'(arready), 32'd1);
        end

        // Reset on beat 2 of an 8-beat burst
        issue_ar(1'b1, 32'h0, 8'd7, 2'b01);
        beat("rstb_b0", 32'hA000_0000, 2'b00, 1'b0, 1'b1); tick();
        beat("rstb_b1", 32'hA000_0001, 2'b00, 1'b0, 1'b1); tick();
        beat("rstb_b2", 32'hA000_0002, 2'b00, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstb_rvalid",  32'(rvalid), 32'd0);
        chk("rstb_arready", 32'(arready), 32'd0);
        chk("rstb_rdata",   rdata, 32'd0);
        chk("rstb_rlast",   32'(rlast), 32'd0);
        chk("rstb_rid",     32'(rid), 32'd0);
        tick();
        rst = 1'b0;
        chk("rstb_rel_arready_low", 32'(arready), 32'd0);
        tick();
        chk("rstb_rel_arready_high", 32'(arready), 32'd1);
        chk("rstb_rel_rvalid", 32'(rvalid), 32'd0);
        issue_ar(1'b0, 32'h20, 8'd1, 2'b01);
        beat("after_b0", 32'hA000_0008, 2'b00, 1'b0, 1'b0); tick();
        beat("after_b1", 32'hA000_0009, 2'b00, 1'b1, 1'b0); tick();
        burst_done("after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
